// File: rtl/pt_ctr_axis.sv
// pt_ctr_axis: phase-timer gate for the oversampled PFB input path.
//
// A modulo-MAX_CNT down-counter walks through one frame of MAX_CNT cycles.
// While the counter sits in the pass region (ctr < PAUSE) the AXI-Stream
// is a straight wire from source to sink. While it sits in the pause region
// the source is held off. This produces the M/D oversampling cadence with
// M = MAX_CNT and D = PAUSE.
//
// The counter advances on downstream ready alone, so the pause elapses in
// time even when the source has nothing to send. There is no data register
// and the data path has zero latency.
//
// Handshake: a beat moves on any cycle where s_axis_tvalid & s_axis_tready.
// This is the same cycle as m_axis_tvalid & m_axis_tready, because both
// valid and ready are gated by the same pass term. During pause,
// s_axis_tready is low, so an AXI-compliant source keeps its beat stable and
// nothing is dropped or duplicated. During reset all three handshake
// outputs are forced low.
module pt_ctr_axis #(
    parameter int WIDTH   = 16,
    parameter int MAX_CNT = 32,
    parameter int START   = 23,
    parameter int PAUSE   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [$clog2(MAX_CNT)-1:0] ctr
);

    localparam int CW = $clog2(MAX_CNT);

    // PAUSE may equal MAX_CNT, and MAX_CNT need not fit in CW bits when it
    // is a power of two. The pass compare is therefore done one bit wider.
    localparam logic [CW-1:0] LAST_C  = CW'(MAX_CNT - 1);
    localparam logic [CW-1:0] START_C = CW'(START);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   PAUSE_C = (CW + 1)'(PAUSE);

    logic [CW-1:0] ctr_q;
    logic [CW-1:0] ctr_d;
    logic          pass;
    logic          at_zero;

    // Next phase: explicit wrap from 0 to MAX_CNT-1, so a non-power-of-two
    // frame length wraps correctly. The phase freezes while the sink stalls.
    always_comb begin
        ctr_d = ctr_q;
        if (m_axis_tready) begin
            if (ctr_q == '0) begin
                ctr_d = LAST_C;
            end else begin
                ctr_d = ctr_q - ONE_C;
            end
        end
    end

    // Phase register; reset takes priority over any advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr_q <= START_C;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign at_zero = (ctr_q == '0);
    assign pass    = ({1'b0, ctr_q} < PAUSE_C);

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = pass & s_axis_tvalid & ~rst;
    assign s_axis_tready = pass & m_axis_tready & ~rst;
    assign m_axis_tlast  = pass & at_zero & s_axis_tvalid & ~rst;
    assign ctr           = ctr_q;

endmodule

// File: tb/tb_pt_ctr_axis.sv
// tb_pt_ctr_axis: bench for the phase-timer gate.
// The main instance uses M=64, D=48, START=47, and drives an in-order source.
// A second instance uses M=D=16, START=15, which gives a continuous pass.
// The reference model counts downstream-ready cycles since the last reset.
// The expected phase is (START - advances) mod M.
module tb_pt_ctr_axis;

    localparam int W   = 16;
    localparam int M   = 64;
    localparam int P   = 48;
    localparam int S   = 47;
    localparam int CW  = $clog2(M);
    localparam int M6  = 16;
    localparam int P6  = 16;
    localparam int S6  = 15;
    localparam int CW6 = $clog2(M6);

    // clock / reset block
    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic [W-1:0] s_data  = '0;
    logic         s_valid = 1'b0;
    logic         m_ready = 1'b0;

    always #5 clk = ~clk;

    logic          s_ready,  m_valid,  m_tlast;
    logic [W-1:0]  m_data;
    logic [CW-1:0] ctr;
    logic          s_ready6, m_valid6, m_tlast6;
    logic [W-1:0]  m_data6;
    logic [CW6-1:0] ctr6;

    pt_ctr_axis #(.WIDTH(W), .MAX_CNT(M), .START(S), .PAUSE(P)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_tlast),
        .ctr           (ctr)
    );

    pt_ctr_axis #(.WIDTH(W), .MAX_CNT(M6), .START(S6), .PAUSE(P6)) u_cont (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready6),
        .m_axis_tdata  (m_data6),
        .m_axis_tvalid (m_valid6),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_tlast6),
        .ctr           (ctr6)
    );

    // scoreboard state
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];
    int           src_mode = 0;   // 0: always valid, counting data; 1: idle; 2: random
    bit           pending  = 1'b0;
    bit           took     = 1'b0;
    logic [W-1:0] seq      = '0;
    int           adv      = 0;
    int           adv6     = 0;
    bit           known    = 1'b0;
    int           tlast_seen = 0;

    function automatic int pmod(input int a, input int m);
        int r;
        r = a % m;
        return (r < 0) ? r + m : r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: one clock cycle of stimulus; the source holds a beat until it is taken
    task automatic step(input bit r, input bit mr);
        @(negedge clk);
        rst     = r;
        m_ready = mr;
        if (took) pending = 1'b0;
        if (src_mode == 1) begin
            if (pending) begin
                void'(exp_q.pop_back());
                pending = 1'b0;
            end
            s_valid = 1'b0;
        end else if (!pending) begin
            if (src_mode == 0 || $urandom_range(0, 2) != 0) begin
                s_data  = (src_mode == 0) ? seq : W'($urandom);
                seq     = seq + 1'b1;
                s_valid = 1'b1;
                pending = 1'b1;
                exp_q.push_back(s_data);
            end else begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
            end
        end
        #4;
        took = s_valid && s_ready;
    endtask

    // monitor: compares every cycle against the phase model and pops beats on transfers
    initial begin : monitor
        int e;
        int e6;
        bit pass;
        forever begin
            @(negedge clk);
            #2;
            check("tdata_passthru", m_data, s_data);
            check("u6_tdata_passthru", m_data6, s_data);
            if (rst) begin
                check("rst_m_tvalid", m_valid, 0);
                check("rst_s_tready", s_ready, 0);
                check("rst_m_tlast", m_tlast, 0);
                check("u6_rst_s_tready", s_ready6, 0);
                check("u6_rst_m_tvalid", m_valid6, 0);
                if (known) begin
                    check("rst_cycle_ctr", ctr, pmod(S - adv, M));
                    check("u6_rst_cycle_ctr", ctr6, pmod(S6 - adv6, M6));
                end
                known = 1'b1;
                adv   = 0;
                adv6  = 0;
            end else if (known) begin
                e    = pmod(S - adv, M);
                pass = (e < P);
                check("ctr", ctr, e);
                check("m_tvalid", m_valid, pass & s_valid);
                check("s_tready", s_ready, pass & m_ready);
                check("m_tlast", m_tlast, pass & (e == 0) & s_valid);
                if (pass && s_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: got transfer expected none at %0t", $time);
                    end else begin
                        check("sb_data", m_data, exp_q.pop_front());
                    end
                end
                if (m_tlast) tlast_seen++;
                if (m_ready) adv++;

                e6 = pmod(S6 - adv6, M6);
                check("u6_ctr", ctr6, e6);
                check("u6_s_tready", s_ready6, m_ready);
                check("u6_m_tvalid", m_valid6, s_valid);
                check("u6_m_tlast", m_tlast6, (e6 == 0) & s_valid);
                if (m_ready) adv6++;
            end
        end
    end

    // main sequence and final report
    initial begin
        // steady cadence, always-valid counting source, 8 periods
        src_mode = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        tlast_seen = 0;
        repeat (512) step(1'b0, 1'b1);
        check("t1_tlast_count", tlast_seen, 8);

        // sink stall of 5 cycles at ctr = 10
        step(1'b1, 1'b1);
        repeat (37) step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        repeat (30) step(1'b0, 1'b1);

        // idle source: phase still advances, no valid, no tlast
        src_mode = 1;
        step(1'b1, 1'b1);
        tlast_seen = 0;
        repeat (130) step(1'b0, 1'b1);
        check("t4_no_tlast", tlast_seen, 0);

        // reset pulse in the pause region (ctr = 55)
        src_mode = 0;
        step(1'b1, 1'b1);
        repeat (56) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);

        // random valid, ready and occasional resets
        src_mode = 2;
        repeat (2000) step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));

        check("sb_residual", exp_q.size(), (pending && !took) ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pt_ctr_axis.md
Name: pt_ctr_axis

Overview:
- Phase-timer gate for the oversampled PFB (OSPFB) input path. M = MAX_CNT branches, D = PAUSE decimation.
- Sits between a sample source (for example the impulse generator) and the PFB front end, with AXI-Stream in and out.
- A modulo-MAX_CNT down-counter opens the stream for PAUSE consecutive cycles, then holds the source off for MAX_CNT-PAUSE cycles.
- This pattern repeats, giving the M/D oversampling cadence.

Parameters:
- WIDTH, 16, tdata width in bits.
- MAX_CNT, 32, counter period M (frame length in cycles). Must be >= 2.
- START, 23, counter value loaded at reset. Legal range 0..MAX_CNT-1; normally PAUSE-1.
- PAUSE, 24, D: number of pass-through cycles per period. Legal range 1..MAX_CNT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axis_tdata  in  WIDTH  upstream sample
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  ready to upstream
- m_axis_tdata  out  WIDTH  downstream sample
- m_axis_tvalid  out  1  downstream valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last pass-through sample of the period
- ctr  out  clog2(MAX_CNT)  current phase counter (debug/observability)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Counter ctr has width clog2(MAX_CNT).
  - On rst: ctr <= START.
  - Otherwise, when m_axis_tready = 1: ctr <= (ctr == 0) ? MAX_CNT-1 : ctr-1.
  - When m_axis_tready = 0: ctr holds.
- The counter advances on downstream ready alone, independent of s_axis_tvalid. The pause therefore always elapses in time, even when the source is idle.
- pass = (ctr < PAUSE), computed combinationally.
  - Pass region: ctr = PAUSE-1 down to 0.
  - Pause region: ctr = MAX_CNT-1 down to PAUSE. This region is empty when PAUSE == MAX_CNT, giving a continuous pass.
- Outputs are purely combinational; zero-cycle latency, no data register.
  - m_axis_tdata = s_axis_tdata, always.
  - m_axis_tvalid = pass & s_axis_tvalid & ~rst.
  - s_axis_tready = pass & m_axis_tready & ~rst.
  - m_axis_tlast = pass & (ctr == 0) & s_axis_tvalid & ~rst.
- Reset values:
  - ctr = START.
  - m_axis_tvalid, s_axis_tready and m_axis_tlast are all 0 while rst = 1.
  - m_axis_tdata follows its input.
- Handshake:
  - A transfer occurs on a cycle where s_axis_tvalid & s_axis_tready. This is identical to the downstream m_axis_tvalid & m_axis_tready.
  - During pause, s_axis_tready = 0, so the source must hold its sample; no sample is dropped or duplicated.
- Wrap-around: from ctr = 0 the next value is MAX_CNT-1. With PAUSE < MAX_CNT, that value is in the pause region.
- Simultaneous events:
  - rst has priority over the ctr advance.
  - m_axis_tready low in either region freezes ctr and holds the phase.
- Reset mid-operation: ctr reloads START on the next edge, regardless of phase. Handshake outputs are 0 during the reset cycle.
- Non-power-of-two MAX_CNT must wrap correctly; there is no reliance on natural binary overflow.

Test Plan:
- Test 1: MAX_CNT=64, PAUSE=48, START=47, source = impulse generator (64-cycle period, phase 49), m_axis_tready held 1 after reset.
  - Cycles 1-48: m_axis_tvalid=1, source samples 0..47.
  - Cycles 49-64: m_axis_tvalid=0, s_axis_tready=0.
  - Cycles 65-112: samples 48..63, then 0..31.
  - The impulse value 1 appears at cycle 66 (ctr=46). The pattern repeats for 8 periods.
- Test 2: same configuration.
  - m_axis_tlast=1 exactly on cycles 48, 112, 176 (ctr==0).
  - ctr reads 63 on cycles 49, 113, 177.
- Test 3: deassert m_axis_tready for 5 cycles at ctr=10.
  - ctr stays at 10; s_axis_tready=0; the source sample is held.
  - After tready returns, the stream resumes at the same sample with no loss.
- Test 4: hold s_axis_tvalid=0 throughout.
  - ctr still counts 47→0→63→48→47 with tready=1.
  - m_axis_tvalid=0 at all times.
- Test 5: assert rst for 1 cycle at ctr=55 (pause region).
  - The next cycle has ctr=47 and pass=1.
  - During the rst cycle, s_axis_tready=0 and m_axis_tvalid=0.
- Test 6: PAUSE=MAX_CNT=16, START=15.
  - s_axis_tready is permanently equal to m_axis_tready.
  - tlast occurs every 16 cycles.
